module_cmd_rx: RTL

Front-end receiver for the 24-bit board-control instruction stream. It takes the single-ended outputs of the Module_SDO/Module_clk LVDS input buffers and the Module_EN frame strobe in `top`, and oversamples them in the `clk_in` domain. It deserialises the stream MSB-first into 24-bit command words and hands each word, through a 2-entry buffer with a valid/ready handshake, to the command decoder that drives the CSB/SCLK/MOSI channel SPI masters.

---
 rtl/module_cmd_rx.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/module_cmd_rx.sv
// Serial 24-bit command receiver: oversamples SPI-like inputs, deserialises MSB-first words
// and queues them in a 2-entry buffer. Optional idle timeout enabled by `CMD_RX_TIMEOUT_EN.
module module_cmd_rx #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        spi_en_n,
  input  logic        spi_clk,
  input  logic        spi_sdo,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [23:0] cmd_data,
  output logic        busy,
  output logic        frame_err,
  output logic        ovf_flag,
  input  logic        ovf_clr
);

  localparam logic [4:0] LastBit = 5'd23;

  // Synchronisers and edge history
  logic [SYNC_STAGES-1:0] en_sync_q, clk_sync_q, sdo_sync_q;
  logic                   en_hist_q, clk_hist_q;
  logic                   en_s, clk_s, sdo_s;

  // Deserialiser state
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [23:0] shift_q, shift_d;
  logic        push_q, push_d;
  logic [23:0] push_word_q, push_word_d;
  logic        frame_err_q;
  logic        abort;

  // Buffer state
  logic [1:0][23:0] mem_q;
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             ovf_q;
  logic             pop, accept, ovf_event;

  logic clk_rise, en_rise, en_fall, timeout_hit;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      en_sync_q  <= '1;
      clk_sync_q <= '0;
      sdo_sync_q <= '0;
      en_hist_q  <= 1'b1;
      clk_hist_q <= 1'b0;
    end else begin
      en_sync_q  <= {en_sync_q[SYNC_STAGES-2:0], spi_en_n};
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], spi_clk};
      sdo_sync_q <= {sdo_sync_q[SYNC_STAGES-2:0], spi_sdo};
      en_hist_q  <= en_s;
      clk_hist_q <= clk_s;
    end
  end

  assign en_s  = en_sync_q[SYNC_STAGES-1];
  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign sdo_s = sdo_sync_q[SYNC_STAGES-1];

  assign clk_rise = ~clk_hist_q & clk_s & ~en_s;
  assign en_rise  = ~en_hist_q & en_s;
  assign en_fall  = en_hist_q & ~en_s;
  assign busy     = (bit_cnt_q != 5'd0);

`ifdef CMD_RX_TIMEOUT_EN
  logic [15:0] idle_q, idle_d;

  assign timeout_hit = busy && (idle_q == 16'(TIMEOUT_CYCLES - 1));

  always_comb begin
    idle_d = 16'd0;
    if (!clk_rise && busy && !timeout_hit) begin
      idle_d = idle_q + 16'd1;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      idle_q <= 16'd0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Enable transitions take priority; a bit edge cannot coincide with an en rise anyway
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    push_d      = 1'b0;
    push_word_d = push_word_q;
    abort       = 1'b0;
    if (en_fall) begin
      bit_cnt_d = 5'd0;
    end else if (en_rise) begin
      abort     = busy;
      bit_cnt_d = 5'd0;
    end else if (clk_rise) begin
      shift_d = {shift_q[22:0], sdo_s};
      if (bit_cnt_q == LastBit) begin
        bit_cnt_d   = 5'd0;
        push_d      = 1'b1;
        push_word_d = shift_d;
      end else begin
        bit_cnt_d = bit_cnt_q + 5'd1;
      end
    end else if (timeout_hit) begin
      abort     = 1'b1;
      bit_cnt_d = 5'd0;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      bit_cnt_q   <= 5'd0;
      shift_q     <= 24'd0;
      push_q      <= 1'b0;
      push_word_q <= 24'd0;
      frame_err_q <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      push_word_q <= push_word_d;
      frame_err_q <= abort;
    end
  end

  assign frame_err = frame_err_q;

  // Two-entry buffer; a full buffer still accepts a push when the head pops in the same cycle
  assign cmd_valid = (count_q != 2'd0);
  assign cmd_data  = mem_q[rd_ptr_q];
  assign pop       = cmd_valid & cmd_ready;
  assign accept    = push_q & ((count_q != 2'd2) | pop);
  assign ovf_event = push_q & (count_q == 2'd2) & ~pop;

  always_comb begin
    count_d = count_q;
    unique case ({accept, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      ovf_q    <= 1'b0;
    end else begin
      if (accept) begin
        mem_q[wr_ptr_q] <= push_word_q;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
      if (ovf_event) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign ovf_flag = ovf_q;

endmodule
